bus_arbiter: RTL and testbench

- Arbitrates the shared system bus among NUM_MASTERS bus-interface masters, e.g. instruction-fetch bus_if and memory-stage bus_if.
- Consumes each master's active-low request and returns an active-low grant.
- Multiplexes the granted master's address, strobe, direction and write data onto the single slave-side bus.
- Sits directly downstream of every CPU bus interface and upstream of the slave address decoder.

---
 rtl/bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter for the shared system bus. It sits between the CPU bus
// interfaces (instruction fetch, memory stage, ...) and the slave address
// decoder. Each master raises an active-low request and receives an
// active-low grant. The granted master's address, strobe, direction and write
// data are multiplexed onto the single slave-side bus.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   reset_     synchronous reset, active-low
//   m_req_     per-master request, active-low
//   m_grnt_    per-master grant, active-low, registered, at most one bit low
//   m_addr     master addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_as_      master address strobes, active-low
//   m_rw       master direction, 1 = read, 0 = write
//   m_wr_data  master write data, master i at [i*DATA_W +: DATA_W]
//   s_addr     muxed address to slaves
//   s_as_      muxed address strobe, active-low
//   s_rw       muxed direction
//   s_wr_data  muxed write data
//   owner      index of the current or last owner, registered
//   bus_busy   high while any grant is asserted
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 2
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic [NUM_MASTERS-1:0]        m_req_,
  output logic [NUM_MASTERS-1:0]        m_grnt_,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_as_,
  input  logic [NUM_MASTERS-1:0]        m_rw,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_as_,
  output logic                          s_rw,
  output logic [DATA_W-1:0]             s_wr_data,
  output logic [IDX_W-1:0]              owner,
  output logic                          bus_busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         owner_nxt;
  logic [NUM_MASTERS-1:0]   grant, grant_nxt;   // active-high internally
  logic [NUM_MASTERS-1:0]   req;
  logic                     found;
  logic [IDX_W-1:0]         winner;
  logic [NUM_MASTERS-1:0]   winner_oh;
  logic                     owner_req;

  assign req       = ~m_req_;
  assign owner_req = |(grant & req);   // current owner still requesting

  // Round-robin pick: the requester with the smallest forward distance from
  // the current owner wins. The owner itself sits at the far end of the scan
  // (distance NUM_MASTERS) and is excluded entirely while it is releasing the
  // bus, so a glitching release never re-selects it.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    int best_d;
    int d;
    found     = 1'b0;
    winner    = owner;
    winner_oh = '0;
    best_d    = NUM_MASTERS + 1;
    d         = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      d = (i - int'(owner) + NUM_MASTERS) % NUM_MASTERS;
      if (d == 0) d = NUM_MASTERS;
      if (req[i] && d < best_d && !(state == GRANT && d == NUM_MASTERS)) begin
        best_d    = d;
        found     = 1'b1;
        winner    = IDX_W'(i);
        winner_oh = '0;
        winner_oh[i] = 1'b1;
      end
    end
  end

  // Next-state and next-grant logic
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    grant_nxt = grant;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          owner_nxt = winner;
          grant_nxt = winner_oh;
        end
      end
      GRANT: begin
        // No preemption: only a release by the owner moves the grant.
        if (!owner_req) begin
          if (found) begin
            owner_nxt = winner;
            grant_nxt = winner_oh;   // hand over with no dead cycle
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;          // owner keeps its value for fairness
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_) begin
      state <= IDLE;
      owner <= IDX_W'(NUM_MASTERS - 1);   // master 0 wins the first scan
      grant <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      grant <= grant_nxt;
    end
  end

  assign m_grnt_  = ~grant;
  assign bus_busy = (state == GRANT);

  // Slave-side mux from the registered owner; idle bus parks as a read with
  // the strobe deasserted.
  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (state == GRANT && owner == IDX_W'(i)) begin
        s_addr    = m_addr[i*ADDR_W +: ADDR_W];
        s_as_     = m_as_[i];
        s_rw      = m_rw[i];
        s_wr_data = m_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter (4 masters). Each step pushes the expected
// grant/owner/busy into a scoreboard queue before the clock edge; after the
// edge the entry is popped and compared with the DUT, together with the
// slave-side fields derived from the expected owner.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int NM = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset_;
  logic [NM-1:0]     m_req_;
  logic [NM-1:0]     m_grnt_;
  logic [NM*AW-1:0]  m_addr;
  logic [NM-1:0]     m_as_;
  logic [NM-1:0]     m_rw;
  logic [NM*DW-1:0]  m_wr_data;
  logic [AW-1:0]     s_addr;
  logic              s_as_;
  logic              s_rw;
  logic [DW-1:0]     s_wr_data;
  logic [IW-1:0]     owner;
  logic              bus_busy;

  bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .m_req_    (m_req_),
    .m_grnt_   (m_grnt_),
    .m_addr    (m_addr),
    .m_as_     (m_as_),
    .m_rw      (m_rw),
    .m_wr_data (m_wr_data),
    .s_addr    (s_addr),
    .s_as_     (s_as_),
    .s_rw      (s_rw),
    .s_wr_data (s_wr_data),
    .owner     (owner),
    .bus_busy  (bus_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NM-1:0] grnt;
    logic [IW-1:0] own;
    logic          busy;
  } exp_t;

  exp_t sb_q[$];
  int   total    = 0;
  int   bad      = 0;
  bit   checking = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expected result of the next clock edge.
  task automatic expect_edge(input logic [NM-1:0] grnt, input int own, input logic busy);
    exp_t e;
    e.grnt = grnt;
    e.own  = IW'(own);
    e.busy = busy;
    sb_q.push_back(e);
  endtask

  // Advance one edge, pop the scoreboard and compare.
  task automatic step(input string tag);
    exp_t          e;
    logic [AW-1:0] ea;
    logic          eas, erw;
    logic [DW-1:0] ewd;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      if (e.busy) begin
        ea  = m_addr[int'(e.own)*AW +: AW];
        eas = m_as_[e.own];
        erw = m_rw[e.own];
        ewd = m_wr_data[int'(e.own)*DW +: DW];
      end else begin
        ea  = '0;
        eas = 1'b1;
        erw = 1'b1;
        ewd = '0;
      end
      check({tag, "_grnt"}, 64'(m_grnt_), 64'(e.grnt));
      check({tag, "_owner"}, 64'(owner), 64'(e.own));
      check({tag, "_busy"}, 64'(bus_busy), 64'(e.busy));
      check({tag, "_saddr"}, 64'(s_addr), 64'(ea));
      check({tag, "_sas"}, 64'(s_as_), 64'(eas));
      check({tag, "_srw"}, 64'(s_rw), 64'(erw));
      check({tag, "_swd"}, 64'(s_wr_data), 64'(ewd));
    end
  endtask

  // Grants must be one-hot-low or all-high on every cycle.
  always @(negedge clk) begin
    if (checking) begin
      total++;
      assert ($countones(~m_grnt_) <= 1) else begin
        bad++;
        $error("FAIL grnt_onehot: observed=%b expected=at most one low", m_grnt_);
      end
    end
  end

  initial begin
    reset_ = 1'b0;
    m_req_ = 4'b0000;
    m_as_  = 4'b1111;
    m_rw   = 4'b1111;
    for (int i = 0; i < NM; i++) begin
      m_addr[i*AW +: AW]    = AW'(32'h1000 + i);
      m_wr_data[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
    end
    m_addr[2*AW +: AW] = 30'h100;

    // Reset held two edges with every master requesting
    expect_edge(4'b1111, 3, 1'b0); step("rst0");
    checking = 1'b1;
    expect_edge(4'b1111, 3, 1'b0); step("rst1");
    reset_ = 1'b1;
    expect_edge(4'b1110, 0, 1'b1); step("rst_rel");

    // Master 0 releases, nobody else asks -> idle
    m_req_ = 4'b1111;
    expect_edge(4'b1111, 0, 1'b0); step("rel0");

    // Single request from master 2 with a one-cycle strobe
    m_req_ = 4'b1011;
    expect_edge(4'b1011, 2, 1'b1); step("m2_gnt");
    m_as_[2] = 1'b0;
    expect_edge(4'b1011, 2, 1'b1); step("m2_as_lo");
    m_as_[2] = 1'b1;
    expect_edge(4'b1011, 2, 1'b1); step("m2_as_hi");
    m_req_ = 4'b1111;
    expect_edge(4'b1111, 2, 1'b0); step("m2_rel");

    // Round robin with everyone requesting: reset to re-seed owner = 3
    reset_ = 1'b0;
    m_req_ = 4'b0000;
    expect_edge(4'b1111, 3, 1'b0); step("rr_rst");
    reset_ = 1'b1;
    expect_edge(4'b1110, 0, 1'b1); step("rr_first");
    for (int o = 0; o < NM; o++) begin
      int nxt;
      nxt = (o + 1) % NM;
      expect_edge(~(4'b0001 << o), o, 1'b1); step("rr_hold");
      expect_edge(~(4'b0001 << o), o, 1'b1); step("rr_hold");
      m_req_[o] = 1'b1;
      expect_edge(~(4'b0001 << nxt), nxt, 1'b1); step("rr_switch");
      m_req_ = 4'b0000;
    end

    // No preemption: master 1 owns, master 0 waits
    m_req_ = 4'b1101;
    expect_edge(4'b1101, 1, 1'b1); step("np_m1");
    m_req_ = 4'b1100;
    expect_edge(4'b1101, 1, 1'b1); step("np_hold0");
    expect_edge(4'b1101, 1, 1'b1); step("np_hold1");
    m_req_ = 4'b1110;
    expect_edge(4'b1110, 0, 1'b1); step("np_switch");

    // Owner 1 releases with nobody else requesting, then re-requests
    m_req_ = 4'b1101;
    expect_edge(4'b1101, 1, 1'b1); step("ri_m1");
    m_req_ = 4'b1111;
    expect_edge(4'b1111, 1, 1'b0); step("ri_idle");
    expect_edge(4'b1111, 1, 1'b0); step("ri_idle2");
    m_req_ = 4'b1101;
    expect_edge(4'b1101, 1, 1'b1); step("ri_regnt");
    m_req_ = 4'b1111;
    expect_edge(4'b1111, 1, 1'b0); step("ri_rel");

    // Reset in the middle of a write by master 3
    m_req_ = 4'b0111;
    m_rw[3] = 1'b0;
    m_as_[3] = 1'b0;
    m_wr_data[3*DW +: DW] = 32'hDEAD_BEEF;
    expect_edge(4'b0111, 3, 1'b1); step("mr_m3");
    reset_ = 1'b0;
    expect_edge(4'b1111, 3, 1'b0); step("mr_rst");
    reset_ = 1'b1;
    m_req_ = 4'b1111;
    expect_edge(4'b1111, 3, 1'b0); step("mr_idle");

    // From idle, the last owner is the only requester: scan wraps to itself
    m_req_ = 4'b0111;
    expect_edge(4'b0111, 3, 1'b1); step("wrap_m3");
    m_req_ = 4'b1111;
    expect_edge(4'b1111, 3, 1'b0); step("wrap_rel");

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
